unified_mem_ctrl: RTL
=====================

// Module: unified_mem_ctrl
// PURPOSE
//  Parametrised unified data/instruction memory for the CPU. Lower half of the array holds
//  data, upper half (from IMEM_BASE) holds instructions. NRD registered data-read channels,
//  one data-write port, a registered instruction-fetch port and a streaming instruction
//  loader. After reset a clear FSM zeroes the data region one word per cycle.
// PARAMETERS
//  DATA_W     32          word width (multiple of 8)
//  ADDR_W     22          word-address width; DEPTH = 2**ADDR_W words
//  NRD        2           number of data-read channels (>=1)
//  IMEM_BASE  2**(ADDR_W-1)  first instruction word; data region is [0, IMEM_BASE)
// PORTS
//  clk        in   1              clock, all logic on posedge
//  reset      in   1              synchronous, active-high
//  EN         in   1              data-port enable; 0 = data reads/writes not accepted
//  busy       out  1              1 while clear FSM runs
//  rd_req     in   NRD            per-channel read request
//  rd_addr    in   NRD*ADDR_W     per-channel word address (ch i at [i*ADDR_W +: ADDR_W])
//  rd_data    out  NRD*DATA_W     per-channel read data
//  rd_valid   out  NRD            rd_data[i] valid (1-cycle pulse)
//  rd_err     out  NRD            address was outside data region
//  wr_req     in   1              write request
//  wr_addr    in   ADDR_W         write word address
//  wr_data    in   DATA_W         write data
//  wr_strb    in   DATA_W/8       byte strobes (used only with MEM_BYTE_WE_EN)
//  wr_ack     out  1              write accepted (1-cycle pulse)
//  if_req     in   1              instruction fetch request
//  if_addr    in   ADDR_W         fetch word address
//  if_data    out  DATA_W         fetched instruction
//  if_valid   out  1              if_data valid (1-cycle pulse)
//  ld_start   in   1              reset loader pointer to 0
//  ld_valid   in   1              loader word present
//  ld_data    in   DATA_W         loader word
//  ld_full    out  1              loader pointer reached end of instruction region
// BEHAVIOUR
//  Reset: busy=1, rd_data=0, rd_valid=0, rd_err=0, wr_ack=0, if_data=all-ones, if_valid=0,
//   ld_full=0, loader ptr=0, clear ptr=0, FSM->CLEAR. Instruction region NOT cleared.
//   Reset mid-operation (any state, mid-clear, mid-load) restarts CLEAR from word 0.
//  FSM CLEAR: writes 0 to ram[clr_ptr], clr_ptr++; after word IMEM_BASE-1 -> RUN next cycle.
//   busy high exactly IMEM_BASE cycles after reset deasserts. RUN: busy=0, stays until reset.
//  Data ports accepted only in RUN with EN=1; else dropped: rd_valid=0, wr_ack=0, rd_data holds.
//  Read: rd_req[i] in cycle t -> rd_valid[i]=1 in t+1. addr<IMEM_BASE: rd_data=ram[addr],
//   rd_err=0; else rd_data=0, rd_err=1. Channels independent; same address on all is legal.
//  Write: wr_req in t -> wr_ack=1 in t+1. addr>=IMEM_BASE: array unchanged, wr_ack still 1.
//  Read and write same address same cycle: read-first (read returns old word).
//  Fetch (unaffected by EN/busy): if_req in t -> if_valid in t+1; if_data=ram[if_addr] if
//   if_addr>=IMEM_BASE, else all-ones. if_data holds when no request.
//  Loader (unaffected by EN/busy): ld_start -> ptr=0, ld_full=0 (ld_valid same cycle ignored).
//   ld_valid & !ld_full: ram[IMEM_BASE+ptr]=ld_data, ptr++; when ptr reaches DEPTH-IMEM_BASE
//   ld_full=1, further ld_valid dropped. Loader write and fetch same address: fetch gets old.
//   Loader and data write never collide (disjoint regions).
// CONFIGURATION
//  MEM_BYTE_WE_EN defined: write updates only bytes with wr_strb[b]=1; all-zero strobe
//   writes nothing but still acks. Undefined: wr_strb ignored, full-word write.
// TESTING (ADDR_W=4, NRD=2, IMEM_BASE=8, DATA_W=32)
//  1 reset 1 cycle, preload ram[3]=0x55 -> busy high 8 cycles; then read ch0 addr3 -> 0, err 0.
//  2 write 0xDEADBEEF @5; next cycle ch0,ch1 read @5 -> both rd_valid, both 0xDEADBEEF.
//  3 ram[6]=0x1; write 0x2 @6 with ch1 read @6 same cycle -> rd_data 0x1; reread -> 0x2.
//  4 read ch0 @9 -> rd_data 0, rd_err 1; write @9 -> wr_ack 1, fetch @9 unchanged.
//  5 ld_start, 9 ld_valid words 0xA0..0xA8 -> ld_full after 8th; fetch @8 -> 0xA0,
//    @15 -> 0xA7; fetch @2 -> 0xFFFFFFFF; reset mid-load then fetch @8 -> 0xA0 kept.
//  6 write 0x11223344 @1, then 0xAABBCCDD strb 4'b0010 -> read 0x1122CC44 with
//    MEM_BYTE_WE_EN, 0xAABBCCDD without; EN=0 write -> no wr_ack, ram unchanged.

Source files
------------

// File: rtl/unified_mem_ctrl.sv
// Unified data/instruction RAM: NRD read channels, data write, fetch port, streaming loader
// and a post-reset clear of the data region. Optional macro MEM_BYTE_WE_EN enables byte strobes.
module unified_mem_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 22,
    parameter int NRD       = 2,
    parameter int IMEM_BASE = 2**(ADDR_W-1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  EN,
    output logic                  busy,
    input  logic [NRD-1:0]        rd_req,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_valid,
    output logic [NRD-1:0]        rd_err,
    input  logic                  wr_req,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    output logic                  wr_ack,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_data,
    output logic                  if_valid,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [DATA_W-1:0]     ld_data,
    output logic                  ld_full
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] IBASE    = ADDR_W'(IMEM_BASE);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(IMEM_BASE - 1);
    localparam logic [ADDR_W:0]   LD_SPAN  = (ADDR_W+1)'(DEPTH - IMEM_BASE);

    typedef enum logic {S_CLEAR, S_RUN} state_t;
    state_t state, state_next;

    logic [DATA_W-1:0] ram [DEPTH];
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W:0]   ld_ptr;
    logic [ADDR_W-1:0] ld_addr;
    logic              clr_we;
    logic              data_ok;
    logic              wr_hit;
    logic              ld_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_next;
            if (clr_we)
                clr_ptr <= clr_ptr + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        clr_we     = 1'b0;
        case (state)
            S_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (clr_ptr == CLR_LAST)
                    state_next = S_RUN;
            end
            S_RUN:   state_next = S_RUN;
            default: state_next = S_CLEAR;
        endcase
    end

    // Data ports are live only once the clear has finished; loader and fetch ignore EN/busy.
    assign data_ok = (state == S_RUN) && EN && !reset;
    assign wr_hit  = data_ok && wr_req && (wr_addr < IBASE);
    assign ld_we   = !reset && !ld_start && ld_valid && !ld_full;
    assign ld_addr = IBASE + ld_ptr[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (clr_we && !reset)
            ram[clr_ptr] <= '0;
        if (wr_hit) begin
`ifdef MEM_BYTE_WE_EN
            for (int b = 0; b < DATA_W/8; b++)
                if (wr_strb[b])
                    ram[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
`else
            ram[wr_addr] <= wr_data;
`endif
        end
        if (ld_we)
            ram[ld_addr] <= ld_data;
    end

`ifndef MEM_BYTE_WE_EN
    logic unused_strb;
    assign unused_strb = ^wr_strb;
`endif

    always_ff @(posedge clk) begin
        if (reset || ld_start) begin
            ld_ptr  <= '0;
            ld_full <= 1'b0;
        end else if (ld_we) begin
            ld_ptr <= ld_ptr + 1'b1;
            if (ld_ptr + 1'b1 == LD_SPAN)
                ld_full <= 1'b1;
        end
    end

    // Registered reads sample the array before this edge's writes land (read-first).
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= '0;
            rd_err   <= '0;
            rd_data  <= '0;
            wr_ack   <= 1'b0;
        end else begin
            wr_ack <= data_ok && wr_req;
            for (int i = 0; i < NRD; i++) begin
                rd_valid[i] <= data_ok && rd_req[i];
                if (data_ok && rd_req[i]) begin
                    if (rd_addr[i*ADDR_W +: ADDR_W] < IBASE) begin
                        rd_data[i*DATA_W +: DATA_W] <= ram[rd_addr[i*ADDR_W +: ADDR_W]];
                        rd_err[i] <= 1'b0;
                    end else begin
                        rd_data[i*DATA_W +: DATA_W] <= '0;
                        rd_err[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid <= 1'b0;
            if_data  <= '1;
        end else begin
            if_valid <= if_req;
            if (if_req)
                if_data <= (if_addr >= IBASE) ? ram[if_addr] : '1;
        end
    end

endmodule
